// File: rtl/projectile_pkg.sv
// -----------------------------------------------------------------------------
// projectile_pkg
//   Shared types and helpers for the projectile pool.
//   - slot_state_t : per-slot lifecycle (IDLE -> FLY -> BOOM -> IDLE)
//   - slot_t       : complete per-slot register image
//   - sat_add_vel  : signed saturating add at velocity width
//   Slot storage widths are fixed here (SLOT_POS_W / SLOT_VEL_W). The top-level
//   POS_W / VEL_W parameters default to these values and must stay equal to
//   them.
// -----------------------------------------------------------------------------
package projectile_pkg;

  localparam int SLOT_POS_W = 10;
  localparam int SLOT_VEL_W = 8;
  localparam int BOOM_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    BOOM = 2'd2
  } slot_state_t;

  typedef struct packed {
    slot_state_t                   state;
    logic [SLOT_POS_W-1:0]         x;
    logic [SLOT_POS_W-1:0]         y;
    logic signed [SLOT_VEL_W-1:0]  vx;
    logic signed [SLOT_VEL_W-1:0]  vy;
    logic [BOOM_CNT_W-1:0]         boom_cnt;
  } slot_t;

  // Signed add clamped to the representable velocity range instead of wrapping.
  function automatic logic signed [SLOT_VEL_W-1:0] sat_add_vel(
    input logic signed [SLOT_VEL_W-1:0] a,
    input logic signed [SLOT_VEL_W-1:0] b
  );
    logic signed [SLOT_VEL_W:0] sum;
    sum = {a[SLOT_VEL_W-1], a} + {b[SLOT_VEL_W-1], b};
    // The two top bits disagree only when the true sum left the range.
    if (sum[SLOT_VEL_W] != sum[SLOT_VEL_W-1]) begin
      if (sum[SLOT_VEL_W]) begin
        sat_add_vel = {1'b1, {(SLOT_VEL_W-1){1'b0}}};
      end else begin
        sat_add_vel = {1'b0, {(SLOT_VEL_W-1){1'b1}}};
      end
    end else begin
      sat_add_vel = sum[SLOT_VEL_W-1:0];
    end
  endfunction

endpackage

// File: rtl/projectile_slot.sv
// -----------------------------------------------------------------------------
// projectile_slot
//   One projectile: lifecycle FSM plus per-frame ballistic integration.
//   Optional build macro: PROJECTILE_WIND_EN (adds wind_tick_i / wind_i).
//
//   Ports
//     frame_clk, Reset          frame clock, async active-high reset
//     alloc_i                   load launch values this edge (only honoured in IDLE)
//     launch_x_i, launch_y_i    muzzle position
//     vx_init_i, vy_init_i      signed launch velocity
//     box_x0_i..box_y1_i        enemy hit box, half-open [x0,x1) x [y0,y1)
//     ground_y_i                terrain line, y >= ground_y_i means landed
//     wind_tick_i, wind_i       (wind build) apply signed wind to vx this edge
//     state_o                   current lifecycle state
//     x_o, y_o                  position; the muzzle position while IDLE
//     hit_o                     this slot terminates on the enemy this edge
// -----------------------------------------------------------------------------
module projectile_slot
  import projectile_pkg::*;
#(
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479,
  parameter int GRAVITY     = 1,
  parameter int VY_MAX      = 20,
  parameter int BOOM_FRAMES = 8
) (
  input  logic                         frame_clk,
  input  logic                         Reset,
  input  logic                         alloc_i,
  input  logic [SLOT_POS_W-1:0]        launch_x_i,
  input  logic [SLOT_POS_W-1:0]        launch_y_i,
  input  logic signed [SLOT_VEL_W-1:0] vx_init_i,
  input  logic signed [SLOT_VEL_W-1:0] vy_init_i,
  input  logic [SLOT_POS_W+1:0]        box_x0_i,
  input  logic [SLOT_POS_W+1:0]        box_x1_i,
  input  logic [SLOT_POS_W+1:0]        box_y0_i,
  input  logic [SLOT_POS_W+1:0]        box_y1_i,
  input  logic [SLOT_POS_W-1:0]        ground_y_i,
`ifdef PROJECTILE_WIND_EN
  input  logic                         wind_tick_i,
  input  logic signed [3:0]            wind_i,
`endif
  output slot_state_t                  state_o,
  output logic [SLOT_POS_W-1:0]        x_o,
  output logic [SLOT_POS_W-1:0]        y_o,
  output logic                         hit_o
);

  // Two guard bits let one signed compare catch both underflow and overflow.
  localparam int AW = SLOT_POS_W + 2;

  localparam logic signed [AW-1:0]         X_LIM     = AW'(X_MAX);
  localparam logic signed [AW-1:0]         Y_LIM     = AW'(Y_MAX);
  localparam logic signed [SLOT_VEL_W-1:0] GRAV      = SLOT_VEL_W'(GRAVITY);
  localparam logic signed [SLOT_VEL_W-1:0] VY_LIM    = SLOT_VEL_W'(VY_MAX);
  localparam logic [BOOM_CNT_W-1:0]        BOOM_INIT = BOOM_CNT_W'(BOOM_FRAMES - 1);

  slot_t q, d;

  logic signed [AW-1:0]         nx, ny;
  logic signed [SLOT_VEL_W-1:0] vy_next;
  logic                         in_box, landed, off_screen;

  // NOTE: the state register is the only place with non-blocking assignments;
  // everything that feeds it is computed combinationally below.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      q <= '{state: IDLE, default: '0};
    end else begin
      q <= d;
    end
  end

  // Candidate next position and termination conditions, all from current q.
  always_comb begin
    nx = $signed({2'b00, q.x}) + $signed({{(AW-SLOT_VEL_W){q.vx[SLOT_VEL_W-1]}}, q.vx});
    ny = $signed({2'b00, q.y}) + $signed({{(AW-SLOT_VEL_W){q.vy[SLOT_VEL_W-1]}}, q.vy});

    in_box = ({2'b00, q.x} >= box_x0_i) && ({2'b00, q.x} < box_x1_i) &&
             ({2'b00, q.y} >= box_y0_i) && ({2'b00, q.y} < box_y1_i);
    landed = (q.y >= ground_y_i);
    off_screen = nx[AW-1] || (nx > X_LIM) || ny[AW-1] || (ny > Y_LIM);

    // Gravity first (saturating), then the terminal-velocity clamp.
    vy_next = sat_add_vel(q.vy, GRAV);
    if (vy_next > VY_LIM) begin
      vy_next = VY_LIM;
    end
  end

  // NOTE: d and hit_o take a full default before the case, so no path through
  // this block leaves them unassigned and no latch can be inferred.
  always_comb begin
    d     = q;
    hit_o = 1'b0;
    unique case (q.state)
      IDLE: begin
        if (alloc_i) begin
          d.state    = FLY;
          d.x        = launch_x_i;
          d.y        = launch_y_i;
          d.vx       = vx_init_i;
          d.vy       = vy_init_i;
          d.boom_cnt = '0;
        end
      end
      FLY: begin
        // Priority: enemy hit, then ground, then leaving the screen. On any
        // termination the last in-range position is held for the explosion.
        if (in_box) begin
          hit_o      = 1'b1;
          d.state    = BOOM;
          d.boom_cnt = BOOM_INIT;
        end else if (landed || off_screen) begin
          d.state    = BOOM;
          d.boom_cnt = BOOM_INIT;
        end else begin
          d.x  = nx[SLOT_POS_W-1:0];
          d.y  = ny[SLOT_POS_W-1:0];
          d.vy = vy_next;
`ifdef PROJECTILE_WIND_EN
          if (wind_tick_i) begin
            d.vx = sat_add_vel(q.vx, {{(SLOT_VEL_W-4){wind_i[3]}}, wind_i});
          end
`endif
        end
      end
      BOOM: begin
        if (q.boom_cnt == '0) begin
          d.state = IDLE;
        end else begin
          d.boom_cnt = q.boom_cnt - 1'b1;
        end
      end
      default: begin
        d.state = IDLE;
      end
    endcase
  end

  assign state_o = q.state;
  // An idle slot shows the shell sitting in the muzzle.
  assign x_o = (q.state == IDLE) ? launch_x_i : q.x;
  assign y_o = (q.state == IDLE) ? launch_y_i : q.y;

endmodule

// File: rtl/projectile_pool.sv
// -----------------------------------------------------------------------------
// projectile_pool
//   Pool of NUM_SLOTS ballistic projectiles fired from the player tank.
//   Handles launch allocation (lowest idle slot), enemy-hit arbitration
//   (lowest hitting slot) and the saturating shot counter.
//   Optional build macro: PROJECTILE_WIND_EN (adds signed 4-bit 'wind' input,
//   applied to every flying slot's vx once every 8 frames).
//
//   Ports
//     frame_clk, Reset            frame clock, async active-high reset
//     tank_x, tank_y              firing tank origin
//     enemy_x, enemy_y            target tank origin
//     ground_y                    terrain line
//     fire                        launch request, sampled each frame
//     vx_init, vy_init            signed launch velocity (vy < 0 is upward)
//     wind                        (wind build) signed wind
//     fire_ready                  at least one slot is idle
//     bullet_x, bullet_y          packed slot positions, slot i at [i*POS_W +: POS_W]
//     bullet_active, bullet_boom  per-slot FLY / BOOM flags
//     hit, hit_slot               one-frame enemy impact pulse and its slot
//     shots_fired                 launches, saturating at 255
// -----------------------------------------------------------------------------
module projectile_pool
  import projectile_pkg::*;
#(
  parameter int NUM_SLOTS   = 4,
  parameter int POS_W       = SLOT_POS_W,
  parameter int VEL_W       = SLOT_VEL_W,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479,
  parameter int GRAVITY     = 1,
  parameter int VY_MAX      = 20,
  parameter int MUZZLE_XOFF = 35,
  parameter int MUZZLE_YOFF = 15,
  parameter int HIT_XOFF    = 30,
  parameter int HIT_YOFF    = 25,
  parameter int HIT_W       = 40,
  parameter int HIT_H       = 30,
  parameter int BOOM_FRAMES = 8,
  localparam int SLOT_IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                       frame_clk,
  input  logic                       Reset,
  input  logic [POS_W-1:0]           tank_x,
  input  logic [POS_W-1:0]           tank_y,
  input  logic [POS_W-1:0]           enemy_x,
  input  logic [POS_W-1:0]           enemy_y,
  input  logic [POS_W-1:0]           ground_y,
  input  logic                       fire,
  input  logic signed [VEL_W-1:0]    vx_init,
  input  logic signed [VEL_W-1:0]    vy_init,
`ifdef PROJECTILE_WIND_EN
  input  logic signed [3:0]          wind,
`endif
  output logic                       fire_ready,
  output logic [NUM_SLOTS*POS_W-1:0] bullet_x,
  output logic [NUM_SLOTS*POS_W-1:0] bullet_y,
  output logic [NUM_SLOTS-1:0]       bullet_active,
  output logic [NUM_SLOTS-1:0]       bullet_boom,
  output logic                       hit,
  output logic [SLOT_IDX_W-1:0]      hit_slot,
  output logic [7:0]                 shots_fired
);

  localparam int AW = POS_W + 2;

  logic [POS_W-1:0] launch_x, launch_y;
  logic [AW-1:0]    box_x0, box_x1, box_y0, box_y1;

  slot_state_t      slot_state [NUM_SLOTS];
  logic [POS_W-1:0] slot_x     [NUM_SLOTS];
  logic [POS_W-1:0] slot_y     [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_idle, slot_hit, alloc_vec;

  logic                  hit_q, hit_d;
  logic [SLOT_IDX_W-1:0] hit_slot_q, hit_slot_d;
  logic [7:0]            shots_q, shots_d;
  logic                  alloc_found;

  // Muzzle and enemy box are shared by every slot. The box bounds carry two
  // extra bits so an enemy near the right/bottom edge cannot wrap the box.
  assign launch_x = tank_x + POS_W'(MUZZLE_XOFF);
  assign launch_y = tank_y + POS_W'(MUZZLE_YOFF);
  assign box_x0   = {2'b00, enemy_x} + AW'(HIT_XOFF);
  assign box_x1   = box_x0 + AW'(HIT_W);
  assign box_y0   = {2'b00, enemy_y} + AW'(HIT_YOFF);
  assign box_y1   = box_y0 + AW'(HIT_H);

`ifdef PROJECTILE_WIND_EN
  logic [2:0] wind_cnt_q;
  logic       wind_tick;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      wind_cnt_q <= '0;
    end else begin
      wind_cnt_q <= wind_cnt_q + 3'd1;
    end
  end

  assign wind_tick = (wind_cnt_q == 3'd7);
`endif

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    projectile_slot #(
      .X_MAX      (X_MAX),
      .Y_MAX      (Y_MAX),
      .GRAVITY    (GRAVITY),
      .VY_MAX     (VY_MAX),
      .BOOM_FRAMES(BOOM_FRAMES)
    ) u_slot (
      .frame_clk  (frame_clk),
      .Reset      (Reset),
      .alloc_i    (alloc_vec[g]),
      .launch_x_i (launch_x),
      .launch_y_i (launch_y),
      .vx_init_i  (vx_init),
      .vy_init_i  (vy_init),
      .box_x0_i   (box_x0),
      .box_x1_i   (box_x1),
      .box_y0_i   (box_y0),
      .box_y1_i   (box_y1),
      .ground_y_i (ground_y),
`ifdef PROJECTILE_WIND_EN
      .wind_tick_i(wind_tick),
      .wind_i     (wind),
`endif
      .state_o    (slot_state[g]),
      .x_o        (slot_x[g]),
      .y_o        (slot_y[g]),
      .hit_o      (slot_hit[g])
    );

    assign slot_idle[g]                = (slot_state[g] == IDLE);
    assign bullet_active[g]            = (slot_state[g] == FLY);
    assign bullet_boom[g]              = (slot_state[g] == BOOM);
    assign bullet_x[g*POS_W +: POS_W]  = slot_x[g];
    assign bullet_y[g*POS_W +: POS_W]  = slot_y[g];
  end

  assign fire_ready = |slot_idle;

  // Allocation uses the states before this edge, so a slot that terminates on
  // the same edge is in BOOM next frame and is never picked here.
  always_comb begin
    alloc_vec   = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (fire && slot_idle[i] && !alloc_found) begin
        alloc_vec[i] = 1'b1;
        alloc_found  = 1'b1;
      end
    end
  end

  // Walk from the top so the lowest hitting slot is the one that sticks.
  always_comb begin
    hit_d      = 1'b0;
    hit_slot_d = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (slot_hit[i]) begin
        hit_d      = 1'b1;
        hit_slot_d = SLOT_IDX_W'(i);
      end
    end
  end

  always_comb begin
    shots_d = shots_q;
    if (fire && fire_ready && (shots_q != 8'hFF)) begin
      shots_d = shots_q + 8'd1;
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      hit_q      <= 1'b0;
      hit_slot_q <= '0;
      shots_q    <= '0;
    end else begin
      hit_q      <= hit_d;
      hit_slot_q <= hit_slot_d;
      shots_q    <= shots_d;
    end
  end

  assign hit         = hit_q;
  assign hit_slot    = hit_slot_q;
  assign shots_fired = shots_q;

endmodule

// File: tb/tb_projectile_pool.sv
// -----------------------------------------------------------------------------
// tb_projectile_pool
//   Directed bench for projectile_pool (default parameters). Expected values
//   are hand-derived from the ballistic rules: launch at tank + (35,15), then
//   per frame x += vx, y += vy, vy = min(vy+1, 20); termination checked on the
//   position before the update. With PROJECTILE_WIND_EN defined the wind
//   steps are also exercised.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_projectile_pool;

  logic              frame_clk = 1'b0;
  logic              Reset;
  logic [9:0]        tank_x, tank_y, enemy_x, enemy_y, ground_y;
  logic              fire;
  logic signed [7:0] vx_init, vy_init;
  logic signed [3:0] wind;
  logic              fire_ready;
  logic [39:0]       bullet_x, bullet_y;
  logic [3:0]        bullet_active, bullet_boom;
  logic              hit;
  logic [1:0]        hit_slot;
  logic [7:0]        shots_fired;

  int passed = 0;
  int total  = 0;

  projectile_pool dut (
    .frame_clk    (frame_clk),
    .Reset        (Reset),
    .tank_x       (tank_x),
    .tank_y       (tank_y),
    .enemy_x      (enemy_x),
    .enemy_y      (enemy_y),
    .ground_y     (ground_y),
    .fire         (fire),
    .vx_init      (vx_init),
    .vy_init      (vy_init),
`ifdef PROJECTILE_WIND_EN
    .wind         (wind),
`endif
    .fire_ready   (fire_ready),
    .bullet_x     (bullet_x),
    .bullet_y     (bullet_y),
    .bullet_active(bullet_active),
    .bullet_boom  (bullet_boom),
    .hit          (hit),
    .hit_slot     (hit_slot),
    .shots_fired  (shots_fired)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance n active edges, then settle 1ns so outputs are sampled off-edge.
  task automatic tick(input int n);
    repeat (n) @(posedge frame_clk);
    #1;
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
  endtask

  function automatic logic [9:0] bx(input int i);
    return bullet_x[i*10 +: 10];
  endfunction

  function automatic logic [9:0] by(input int i);
    return bullet_y[i*10 +: 10];
  endfunction

  initial begin
    Reset = 1'b1; fire = 1'b0; wind = 4'sd0;
    tank_x = 10'd100; tank_y = 10'd300;
    enemy_x = 10'd500; enemy_y = 10'd0;      // hit box [530,570)x[25,55): out of the way
    ground_y = 10'd470;
    vx_init = 8'sd7; vy_init = -8'sd10;
    #2;

    // Reset state; idle slots show the muzzle (135,315).
    check("rst_fire_ready", 32'(fire_ready), 32'd1);
    check("rst_active", 32'(bullet_active), 32'd0);
    check("rst_boom", 32'(bullet_boom), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_shots", 32'(shots_fired), 32'd0);
    check("idle_x0", 32'(bx(0)), 32'd135);
    check("idle_y0", 32'(by(0)), 32'd315);
    tick(1);
    Reset = 1'b0;

    // Ballistics: vx=7, vy=-10 from (135,315).
    fire = 1'b1; tick(1); fire = 1'b0;
    check("launch_active", 32'(bullet_active), 32'b0001);
    check("launch_x", 32'(bx(0)), 32'd135);
    check("launch_y", 32'(by(0)), 32'd315);
    check("launch_shots", 32'(shots_fired), 32'd1);
    tick(1);
    check("fly1_x", 32'(bx(0)), 32'd142);
    check("fly1_y", 32'(by(0)), 32'd305);
    tick(1);
    check("fly2_x", 32'(bx(0)), 32'd149);
    check("fly2_y", 32'(by(0)), 32'd296);
    tick(1);
    check("fly3_x", 32'(bx(0)), 32'd156);
    check("fly3_y", 32'(by(0)), 32'd288);
    check("idle_x1", 32'(bx(1)), 32'd135);
    tick(1);
    check("fly4_y_vy_m7", 32'(by(0)), 32'd281);   // 288 + (-7)

    // Asynchronous reset mid-flight, observed before any clock edge.
    #3; Reset = 1'b1; #1;
    check("async_active", 32'(bullet_active), 32'd0);
    check("async_shots", 32'(shots_fired), 32'd0);
    check("async_ready", 32'(fire_ready), 32'd1);
    tick(1);
    Reset = 1'b0;

    // Pool exhaustion: fire held 6 frames, only 4 slots.
    fire = 1'b1; tick(6); fire = 1'b0;
    check("pool_active", 32'(bullet_active), 32'b1111);
    check("pool_ready", 32'(fire_ready), 32'd0);
    check("pool_shots", 32'(shots_fired), 32'd4);
    check("pool_x0", 32'(bx(0)), 32'd170);        // 5 updates
    check("pool_x1", 32'(bx(1)), 32'd163);        // 4 updates
    check("pool_x3", 32'(bx(3)), 32'd149);        // 2 updates
    check("pool_y3", 32'(by(3)), 32'd296);
    pulse_reset();

    // Enemy hit: enemy (110,280) -> box [140,180)x[305,335); (142,305) is inside.
    enemy_x = 10'd110; enemy_y = 10'd280;
    fire = 1'b1; tick(1); fire = 1'b0;
    tick(1);
    check("prehit_hit", 32'(hit), 32'd0);
    check("prehit_x", 32'(bx(0)), 32'd142);
    tick(1);
    check("hit_pulse", 32'(hit), 32'd1);
    check("hit_slot0", 32'(hit_slot), 32'd0);
    check("hit_boom", 32'(bullet_boom), 32'b0001);
    check("hit_active", 32'(bullet_active), 32'd0);
    check("hit_hold_x", 32'(bx(0)), 32'd142);
    check("hit_hold_y", 32'(by(0)), 32'd305);
    tick(1);
    check("hit_one_frame", 32'(hit), 32'd0);
    check("boom_f2", 32'(bullet_boom), 32'b0001);
    tick(6);
    check("boom_f8", 32'(bullet_boom), 32'b0001);
    tick(1);
    check("boom_done", 32'(bullet_boom), 32'd0);
    check("boom_ready", 32'(fire_ready), 32'd1);

    // Two shots one frame apart: slot0 hits first, slot1 the frame after.
    fire = 1'b1; tick(2); fire = 1'b0;
    tick(1);
    check("hit2_a", 32'(hit), 32'd1);
    check("hit2_a_slot", 32'(hit_slot), 32'd0);
    tick(1);
    check("hit2_b", 32'(hit), 32'd1);
    check("hit2_b_slot", 32'(hit_slot), 32'd1);
    check("hit2_shots", 32'(shots_fired), 32'd3);
    pulse_reset();

    // Ground boundary: launch y 315 with ground_y 315 lands on the first frame.
    enemy_x = 10'd500; enemy_y = 10'd0; ground_y = 10'd315;
    fire = 1'b1; tick(1); fire = 1'b0;
    tick(1);
    check("ground_boom", 32'(bullet_boom), 32'b0001);
    check("ground_hit", 32'(hit), 32'd0);
    check("ground_y_hold", 32'(by(0)), 32'd315);
    pulse_reset();

    // Right edge: launch x 625, vx 14 -> 639 is legal, 653 terminates.
    ground_y = 10'd470; tank_x = 10'd590; tank_y = 10'd100;
    vx_init = 8'sd14; vy_init = 8'sd0;
    fire = 1'b1; tick(1); fire = 1'b0;
    tick(1);
    check("edge_at_max_active", 32'(bullet_active), 32'b0001);
    check("edge_at_max_x", 32'(bx(0)), 32'd639);
    tick(1);
    check("edge_exit_boom", 32'(bullet_boom), 32'b0001);
    check("edge_exit_x", 32'(bx(0)), 32'd639);
    check("edge_exit_hit", 32'(hit), 32'd0);
    pulse_reset();

    // Left edge: launch x 35, vx -40 -> next x -5 terminates, no wrap.
    tank_x = 10'd0; vx_init = -8'sd40;
    fire = 1'b1; tick(1); fire = 1'b0;
    tick(1);
    check("left_boom", 32'(bullet_boom), 32'b0001);
    check("left_x", 32'(bx(0)), 32'd35);
    pulse_reset();

    // Counter saturation: every shot lands at once, one launch per slot per 10 frames.
    tank_x = 10'd100; tank_y = 10'd300; ground_y = 10'd0;
    vx_init = 8'sd7; vy_init = -8'sd10;
    fire = 1'b1; tick(10);
    check("sat_first_round", 32'(shots_fired), 32'd4);
    tick(690); fire = 1'b0;
    check("sat_255", 32'(shots_fired), 32'd255);
    pulse_reset();

`ifdef PROJECTILE_WIND_EN
    // Wind -2 applied on the 8th edge after reset (counter value 7).
    ground_y = 10'd470; tank_x = 10'd100; tank_y = 10'd50;
    vx_init = 8'sd10; vy_init = 8'sd0; wind = -4'sd2;
    fire = 1'b1; tick(1); fire = 1'b0;         // edge 0
    tick(6);                                    // edges 1..6: x 145..195
    check("wind_pre_x", 32'(bx(0)), 32'd195);
    tick(1);                                    // edge 7: x uses old vx
    check("wind_tick_x", 32'(bx(0)), 32'd205);
    tick(1);                                    // edge 8: vx now 8
    check("wind_after_x", 32'(bx(0)), 32'd213);
    pulse_reset();

    // vx -127 plus wind -2 saturates at -128.
    tank_x = 10'd600; vx_init = -8'sd127;
    tick(6);                                    // edges 0..5
    fire = 1'b1; tick(1); fire = 1'b0;         // edge 6: launch at 635
    tick(1);                                    // edge 7: x 508, vx -> -128
    check("wsat_x1", 32'(bx(0)), 32'd508);
    tick(1);
    check("wsat_x2", 32'(bx(0)), 32'd380);
    pulse_reset();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
